// File: rtl/bram_fifo_pkg.sv
// rtl/bram_fifo_pkg.sv - bram_fifo shared geometry, BRAM limits and build options
// Optional feature macro: FIFO_LEVEL_EN (undefined by default, level port absent).
package bram_fifo_pkg;

  localparam int MAX_ADDR_WIDTH = 11;
  localparam int MAX_DATA_WIDTH = 16;

`ifdef FIFO_LEVEL_EN
  localparam bit LEVEL_EN = 1'b1;
`else
  localparam bit LEVEL_EN = 1'b0;
`endif

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic bit geometry_ok(input int addr_width, input int data_width);
    return (addr_width >= 1) && (addr_width <= MAX_ADDR_WIDTH) &&
           (data_width >= 1) && (data_width <= MAX_DATA_WIDTH);
  endfunction

endpackage

// File: rtl/bram_fifo_if.sv
// rtl/bram_fifo_if.sv - bram_fifo write/read handshake bundle
// Optional feature macro: FIFO_LEVEL_EN adds the level signal.
interface bram_fifo_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;

`ifdef FIFO_LEVEL_EN
  logic [ADDR_WIDTH:0]   level;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, level
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, level
  );
`else
  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
`endif

endinterface

// File: rtl/bram_fifo_ram.sv
// rtl/bram_fifo_ram.sv - generic simple dual-port RAM with registered read port
// q is the FIFO output stage, so it is cleared by rst; array contents are not.
module bram_fifo_ram
  import bram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [fifo_depth(ADDR_WIDTH)];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (re) begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/bram_fifo.sv
// rtl/bram_fifo.sv - first-word-fall-through FIFO on one block RAM
// Optional feature macro: FIFO_LEVEL_EN enables the registered level output.
module bram_fifo
  import bram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  bram_fifo_if.slave  bus
);

  localparam int                  DEPTH    = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  if (!geometry_ok(ADDR_WIDTH, DATA_WIDTH) ||
      bus.ADDR_WIDTH != ADDR_WIDTH || bus.DATA_WIDTH != DATA_WIDTH) begin : g_bad_geometry
    $error("bram_fifo: unsupported or mismatched geometry");
  end

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic [ADDR_WIDTH:0]   ram_cnt_nxt;
  logic                  out_valid;
  logic                  out_valid_nxt;
  logic                  we;
  logic                  re;
  logic                  pop;

  // wr_ready depends on the RAM count only, never on the read side.
  assign bus.wr_ready = (ram_cnt != FULL_CNT);
  assign bus.rd_valid = out_valid;

  always_comb begin
    we  = bus.wr_valid && bus.wr_ready;
    pop = out_valid && bus.rd_ready;
    re  = (ram_cnt != '0) && (!out_valid || bus.rd_ready);

    ram_cnt_nxt = ram_cnt;
    if (we) begin
      ram_cnt_nxt = ram_cnt_nxt + CNT_ONE;
    end
    if (re) begin
      ram_cnt_nxt = ram_cnt_nxt - CNT_ONE;
    end

    out_valid_nxt = out_valid;
    if (re) begin
      out_valid_nxt = 1'b1;
    end else if (pop) begin
      out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (we) begin
        wptr <= wptr + PTR_ONE;
      end
      if (re) begin
        rptr <= rptr + PTR_ONE;
      end
      ram_cnt   <= ram_cnt_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // Reset must win over a write or read landing in the same cycle.
  bram_fifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we && !rst),
    .waddr (wptr),
    .d     (bus.wr_data),
    .re    (re && !rst),
    .raddr (rptr),
    .q     (bus.rd_data)
  );

`ifdef FIFO_LEVEL_EN
  logic [ADDR_WIDTH:0] level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      level_q <= ram_cnt_nxt + (out_valid_nxt ? CNT_ONE : '0);
    end
  end

  assign bus.level = level_q;
`endif

endmodule

// File: tb/tb_bram_fifo.sv
// tb/tb_bram_fifo.sv - directed self-checking bench for bram_fifo (ADDR_WIDTH=2)
// Level checks are compiled in when FIFO_LEVEL_EN is defined.
module tb_bram_fifo;

  localparam int AW = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   nexp;
  int   gaps;
  bit   seen;

  bram_fifo_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bram_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_level(input string tag, input int exp);
`ifdef FIFO_LEVEL_EN
    check(tag, 32'(bus.level), 32'(exp));
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_rd_valid", 32'(bus.rd_valid), 0);
    check("reset_wr_ready", 32'(bus.wr_ready), 1);
    check("reset_rd_data", 32'(bus.rd_data), 0);
    check_level("reset_level", 0);

    // Latency: write at cycle 0, head visible at cycle 2.
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hA1;
    tick();
    bus.wr_valid = 1'b0;
    check("lat_rd_valid_t1", 32'(bus.rd_valid), 0);
    tick();
    check("lat_rd_valid_t2", 32'(bus.rd_valid), 1);
    check("lat_rd_data_t2", 32'(bus.rd_data), 32'hA1);
    check("lat_wr_ready", 32'(bus.wr_ready), 1);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check("lat_drained", 32'(bus.rd_valid), 0);

    // Fill to DEPTH+1, then a dropped write.
    for (int i = 1; i <= 5; i++) begin
      check("fill_wr_ready_before", 32'(bus.wr_ready), 1);
      bus.wr_valid = 1'b1;
      bus.wr_data  = DW'(i);
      tick();
      check_level("fill_level", i);
    end
    check("full_wr_ready", 32'(bus.wr_ready), 0);
    bus.wr_data = 8'h06;
    tick();
    bus.wr_valid = 1'b0;
    check("full_drop_wr_ready", 32'(bus.wr_ready), 0);
    check("full_drop_head", 32'(bus.rd_data), 1);
    check_level("full_drop_level", 5);
    bus.rd_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      check("drain_rd_valid", 32'(bus.rd_valid), 1);
      check("drain_rd_data", 32'(bus.rd_data), 32'(i));
      check_level("drain_level", 6 - i);
      tick();
    end
    bus.rd_ready = 1'b0;
    check("drain_empty", 32'(bus.rd_valid), 0);
    check_level("drain_level_end", 0);

    // Streaming 0..19 with both sides always active.
    nexp = 0;
    gaps = 0;
    seen = 1'b0;
    bus.rd_ready = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      bus.wr_valid = (cyc < 20);
      bus.wr_data  = DW'(cyc);
      if (bus.rd_valid) begin
        if (!seen) begin
          check("stream_first_cycle", 32'(cyc), 2);
        end
        seen = 1'b1;
        check("stream_data", 32'(bus.rd_data), 32'(nexp));
        nexp++;
      end else if (seen && nexp < 20) begin
        gaps++;
      end
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    check("stream_count", 32'(nexp), 20);
    check("stream_gaps", 32'(gaps), 0);
    check("stream_empty", 32'(bus.rd_valid), 0);

    // Backpressure: head 0x33 held while two writes land behind it.
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h33;
    tick();
    bus.wr_data  = 8'h34;
    tick();
    check("bp_head_valid", 32'(bus.rd_valid), 1);
    check("bp_head_data", 32'(bus.rd_data), 32'h33);
    bus.wr_data = 8'h35;
    tick();
    check("bp_hold1", 32'(bus.rd_data), 32'h33);
    bus.wr_data = 8'h36;
    tick();
    check("bp_hold2", 32'(bus.rd_data), 32'h33);
    bus.wr_valid = 1'b0;
    tick();
    check("bp_hold3", 32'(bus.rd_data), 32'h33);
    check("bp_hold3_valid", 32'(bus.rd_valid), 1);
    check_level("bp_level", 4);
    bus.rd_ready = 1'b1;
    tick();
    check("bp_next_head", 32'(bus.rd_data), 32'h34);
    check_level("bp_level_after_pop", 3);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h37;
    tick();
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    check("wr_pop_head", 32'(bus.rd_data), 32'h35);
    check_level("wr_pop_level", 3);

    // Reset with 3 entries stored and a write attempted during reset.
    rst = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h55;
    tick();
    rst = 1'b0;
    bus.wr_valid = 1'b0;
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    check("rst_wr_ready", 32'(bus.wr_ready), 1);
    check("rst_rd_data", 32'(bus.rd_data), 0);
    check_level("rst_level", 0);
    tick();
    check("rst_no_stale", 32'(bus.rd_valid), 0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h7E;
    tick();
    bus.wr_valid = 1'b0;
    check("post_rst_t1", 32'(bus.rd_valid), 0);
    tick();
    check("post_rst_valid", 32'(bus.rd_valid), 1);
    check("post_rst_data", 32'(bus.rd_data), 32'h7E);
    bus.rd_ready = 1'b1;
    tick();
    check("post_rst_empty", 32'(bus.rd_valid), 0);
    tick();
    check("empty_pop_ignored", 32'(bus.rd_valid), 0);
    check("empty_wr_ready", 32'(bus.wr_ready), 1);
    check_level("empty_level", 0);
    bus.rd_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_fifo.md
Name: bram_fifo

Overview:
- Parametrised synchronous first-word-fall-through FIFO on a single block-RAM instance. Replaces the fixed-geometry RAM wrappers wherever a buffered stream is needed, e.g. UART/SPI byte queues and sample buffers.
- Valid/ready on both sides.
- Storage is the RAM array plus the RAM's registered read port, which is also the FIFO output stage.

Parameters:
- ADDR_WIDTH, 8, RAM address bits. DEPTH = 1 << ADDR_WIDTH. Legal range 1..11.
- DATA_WIDTH, 16, payload width. Legal range 1..16 on one iCE40 BRAM.

Ports:
- clk  input  1  sole clock, all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_valid  input  1  producer has data.
- wr_ready  output  1  FIFO accepts data. A write occurs when wr_valid && wr_ready.
- wr_data  input  DATA_WIDTH  write payload.
- rd_valid  output  1  rd_data holds the head entry.
- rd_ready  input  1  consumer takes the head. A pop occurs when rd_valid && rd_ready.
- rd_data  output  DATA_WIDTH  head entry. Driven directly by the RAM read register.
- level  output  ADDR_WIDTH+1  occupancy. Present only with FIFO_LEVEL_EN.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- State:
  - wptr, rptr: ADDR_WIDTH bits each, wrap modulo DEPTH.
  - ram_cnt: ADDR_WIDTH+1 bits, range 0..DEPTH.
  - out_valid: 1 bit, drives rd_valid.
- Reset values: wptr=0, rptr=0, ram_cnt=0, out_valid=0, rd_data=0, wr_ready=1, level=0. RAM contents are not cleared.
- wr_ready = (ram_cnt != DEPTH). It is combinational from state only and never depends on rd_ready or wr_valid.
- Write: mem[wptr] <= wr_data; wptr <= wptr+1.
- RAM read issue: re = (ram_cnt != 0) && (!out_valid || rd_ready).
  - On issue: rd_data <= mem[rptr]; rptr <= rptr+1; out_valid <= 1.
  - On a pop with no issue: out_valid <= 0, and rd_data holds its old value.
- ram_cnt next value = ram_cnt + write − re. A simultaneous write and issue leaves it unchanged.
- Total capacity is DEPTH+1 (RAM plus output register). Occupancy = ram_cnt + out_valid.
- Latency: a write into an empty FIFO at cycle t gives rd_valid=1 at t+2.
- Throughput: sustained one write and one pop per cycle with no bubbles.
- Read/write address collision cannot occur. A read only targets entries whose writes completed in an earlier cycle.
- Full: wr_valid with wr_ready=0 is ignored, and no state changes.
- Empty: rd_ready with rd_valid=0 is ignored.
- rd_data is stable while rd_valid && !rd_ready. re is gated by the issue rule above.
- Wrap-around: the pointers roll over DEPTH-1 to 0 with no special case.
- Reset mid-operation: all in-flight and stored data is discarded. Outputs take their reset values on the cycle after rst is sampled high. rst overrides any simultaneous write or pop.

Optional Feature:
- Macro: FIFO_LEVEL_EN.
- Defined: the level port exists and is registered; it equals occupancy (ram_cnt + out_valid) after every edge. Maximum value DEPTH+1, which fits ADDR_WIDTH+1 bits.
- Undefined: the level port and its register are absent, and all other behaviour is identical.

Decomposition:
- Shared header holds:
  - the DEPTH derivation, as a function of ADDR_WIDTH;
  - the BRAM limits: maximum ADDR_WIDTH 11 and maximum DATA_WIDTH 16;
  - the FIFO_LEVEL_EN default (undefined).
- One sub-module, used for storage: instantiate the existing generic ram (clk, we, waddr, d, re, raddr, q) with ADDR_WIDTH/DATA_WIDTH passed through. Its registered q is rd_data.
- Pointer, count and handshake control is flat in bram_fifo.

Test Plan:
- ADDR_WIDTH=2 (DEPTH 4). After reset, write 0xA1 at cycle 0 → rd_valid=1 and rd_data=0xA1 at cycle 2; wr_ready stays 1.
- Fill: rd_ready=0, write 0x01..0x05 → wr_ready=0 after the 5th write (RAM full with 4, output register holds 1). A 6th write of 0x06 is dropped. Draining then yields 0x01..0x05 in order, and rd_valid=0 afterwards.
- Streaming: wr_valid=1 and rd_ready=1 continuously for 20 writes of 0..19 → output 0..19 with no gaps after the 2-cycle fill; pointers wrap 5 times; no data loss.
- Backpressure: rd_valid=1 with rd_data=0x33, rd_ready=0 for 3 cycles while 2 writes occur → rd_data stays 0x33. The next pop presents the following entry on the next cycle.
- Reset mid-stream: 3 entries stored, assert rst for 1 cycle → next cycle rd_valid=0, wr_ready=1, level=0. A new write 0x7E appears 2 cycles later, with no stale data.
- FIFO_LEVEL_EN defined: level follows 0,1,2,…,5 during fill and 5 down to 0 during drain. A simultaneous write and pop with level 3 keeps level 3.
